// File: rtl/fmul_pkg.sv
// fmul_pkg: 11-bit FloPoCo float layout shared by the fmul arbiter and its users
package fmul_pkg;
  localparam int FP_W    = 11;
  localparam int EXC_HI  = 10;
  localparam int EXC_LO  = 9;
  localparam int SIGN    = 8;
  localparam int EXP_HI  = 7;
  localparam int EXP_LO  = 4;
  localparam int FRAC_HI = 3;
  localparam int FRAC_LO = 0;
  typedef logic [FP_W-1:0] fp_t;
  typedef enum logic [1:0] {ZERO = 2'b00, NORMAL = 2'b01, INF = 2'b10, NAN = 2'b11} exc_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered rotating pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  // scan from the farthest index back toward ptr so the nearest requester wins
  always_comb begin
    grant = '0;
    gidx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        gidx = j;
      end
    end
  end
  // pointer moves just past the winner, only when something was granted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (|grant) ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
endmodule

// File: rtl/fmul_share_arbiter.sv
// fmul_share_arbiter: round-robin sharing of one fmul among N_REQ requesters with tagged result return
module fmul_share_arbiter
  import fmul_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int FMUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FP_W-1:0] req_x,
  input  logic [N_REQ*FP_W-1:0] req_y,
  output logic [FP_W-1:0]       mul_x,
  output logic [FP_W-1:0]       mul_y,
  input  logic [FP_W-1:0]       mul_r,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [N_REQ*FP_W-1:0] rsp_r
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] grant, inflight, busy;
  logic [IW-1:0] gidx, tail_idx;
  logic [FMUL_LAT-1:0] pv;
  logic [IW-1:0] pidx [FMUL_LAT];
  logic tail_v;
  assign busy = inflight | rsp_valid;
  assign req_ready = grant;
  assign tail_v = pv[FMUL_LAT-1];
  assign tail_idx = pidx[FMUL_LAT-1];
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req_valid & ~busy),
    .grant(grant),
    .gidx (gidx)
  );
  // operand mux to the fmul; idle cycles drive zero
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) begin
        mul_x = req_x[i*FP_W +: FP_W];
        mul_y = req_y[i*FP_W +: FP_W];
      end
  end
  // a requester is in flight while any tag stage carries its index
  always_comb begin
    inflight = '0;
    for (int s = 0; s < FMUL_LAT; s++)
      for (int i = 0; i < N_REQ; i++)
        if (pv[s] && pidx[s] == IW'(i)) inflight[i] = 1'b1;
  end
  // tag pipe shadows the fmul stages so each product knows its owner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= '0;
      for (int s = 0; s < FMUL_LAT; s++) pidx[s] <= '0;
    end else begin
      pv[0] <= |grant;
      pidx[0] <= gidx;
      for (int s = 1; s < FMUL_LAT; s++) begin
        pv[s] <= pv[s-1];
        pidx[s] <= pidx[s-1];
      end
    end
  // response slots: capture at pipe tail, clear on handshake, data is held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_r <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (tail_v && tail_idx == IW'(i)) begin
          rsp_valid[i] <= 1'b1;
          rsp_r[i*FP_W +: FP_W] <= mul_r;
        end else if (rsp_ready[i]) rsp_valid[i] <= 1'b0;
    end
  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n) tail_v |-> !rsp_valid[tail_idx]);
endmodule

// File: tb/tb_fmul_share_arbiter.sv
// tb_fmul_share_arbiter: vectors, directed corner sequences and a timestamp-based reference model
module tb_fmul_share_arbiter;
  import fmul_pkg::*;
  localparam int NA = 4, LA = 1, NB = 2, LB = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NA-1:0] a_rv = '0, a_rr, a_sv, a_sr = '1;
  logic [NA*11-1:0] a_x = '0, a_y = '0, a_out;
  fp_t a_mx, a_my, a_mr;
  logic [NB-1:0] b_rv = '0, b_rr, b_sv, b_sr = '1;
  logic [NB*11-1:0] b_x = '0, b_y = '0, b_out;
  fp_t b_mx, b_my, b_mr;
  fp_t a_pipe [LA];
  fp_t b_pipe [LB];
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  bit mout [2][16];
  int mt [2][16];
  fp_t mpend [2][16], mlast [2][16];
  int mptr [2];
  int mcyc = 0;
  typedef struct { fp_t x; fp_t y; fp_t r; } vec_t;
  vec_t tbl [7];

  fmul_share_arbiter #(.N_REQ(NA), .FMUL_LAT(LA)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_rv), .req_ready(a_rr), .req_x(a_x), .req_y(a_y),
    .mul_x(a_mx), .mul_y(a_my), .mul_r(a_mr), .rsp_valid(a_sv), .rsp_ready(a_sr), .rsp_r(a_out));
  fmul_share_arbiter #(.N_REQ(NB), .FMUL_LAT(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_rv), .req_ready(b_rr), .req_x(b_x), .req_y(b_y),
    .mul_x(b_mx), .mul_y(b_my), .mul_r(b_mr), .rsp_valid(b_sv), .rsp_ready(b_sr), .rsp_r(b_out));

  always #5 clk = ~clk;

  function automatic fp_t fmul(fp_t x, fp_t y);
    logic s;
    int e, m;
    s = x[SIGN] ^ y[SIGN];
    if (x[10:9] == 2'b11 || y[10:9] == 2'b11 || (x[10:9] == 2'b00 && y[10:9] == 2'b10) ||
        (x[10:9] == 2'b10 && y[10:9] == 2'b00)) return 11'h600;
    if (x[10:9] == 2'b10 || y[10:9] == 2'b10) return {2'b10, s, 8'h00};
    if (x[10:9] == 2'b00 || y[10:9] == 2'b00) return {2'b00, s, 8'h00};
    m = (16 + int'(x[3:0])) * (16 + int'(y[3:0]));
    e = int'(x[7:4]) + int'(y[7:4]) - 7;
    if (m >= 512) begin
      m = m / 2;
      e = e + 1;
    end
    if (e < 0) return {2'b00, s, 8'h00};
    if (e > 15) return {2'b10, s, 8'h00};
    return {2'b01, s, 4'(e), 4'((m / 16) % 16)};
  endfunction

  always @(posedge clk) begin
    a_pipe[0] <= fmul(a_mx, a_my);
    for (int s = 1; s < LA; s++) a_pipe[s] <= a_pipe[s-1];
    b_pipe[0] <= fmul(b_mx, b_my);
    for (int s = 1; s < LB; s++) b_pipe[s] <= b_pipe[s-1];
  end
  assign a_mr = a_pipe[LA-1];
  assign b_mr = b_pipe[LB-1];

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0;
      for (int i = 0; i < 16; i++) begin
        mout[d][i] = 1'b0;
        mt[d][i] = 0;
        mpend[d][i] = '0;
        mlast[d][i] = '0;
      end
    end
  endtask

  task automatic model_step(input int d, input int n, input int lat, input logic [15:0] rv,
                            input logic [15:0] rr, input logic [15:0] sv, input logic [15:0] sr,
                            input logic [175:0] xs, input logic [175:0] ys, input logic [175:0] rs,
                            input fp_t mx, input fp_t my);
    int g;
    logic [15:0] er, ev;
    logic [175:0] eo;
    fp_t ex, ey;
    g = -1;
    er = '0;
    ev = '0;
    eo = '0;
    ex = '0;
    ey = '0;
    for (int k = 0; k < n; k++) begin
      int j;
      j = (mptr[d] + k) % n;
      if (g < 0 && rv[j] && !mout[d][j]) g = j;
    end
    if (g >= 0) begin
      er[g] = 1'b1;
      ex = xs[g*11 +: 11];
      ey = ys[g*11 +: 11];
    end
    for (int i = 0; i < n; i++) begin
      ev[i] = mout[d][i] && mcyc >= mt[d][i] + lat + 1;
      eo[i*11 +: 11] = ev[i] ? mpend[d][i] : mlast[d][i];
    end
    chk($sformatf("dut%0d req_ready c%0d", d, mcyc), 176'(rr), 176'(er));
    chk($sformatf("dut%0d mul_xy c%0d", d, mcyc), 176'({mx, my}), 176'({ex, ey}));
    chk($sformatf("dut%0d rsp_valid c%0d", d, mcyc), 176'(sv), 176'(ev));
    chk($sformatf("dut%0d rsp_r c%0d", d, mcyc), rs, eo);
    for (int i = 0; i < n; i++)
      if (ev[i] && sr[i]) begin
        mout[d][i] = 1'b0;
        mlast[d][i] = mpend[d][i];
      end
    if (g >= 0) begin
      mout[d][g] = 1'b1;
      mt[d][g] = mcyc;
      mpend[d][g] = fmul(ex, ey);
      mptr[d] = (g + 1) % n;
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      model_step(0, NA, LA, 16'(a_rv), 16'(a_rr), 16'(a_sv), 16'(a_sr), 176'(a_x), 176'(a_y), 176'(a_out), a_mx, a_my);
      model_step(1, NB, LB, 16'(b_rv), 16'(b_rr), 16'(b_sv), 16'(b_sr), 176'(b_x), 176'(b_y), 176'(b_out), b_mx, b_my);
      mcyc++;
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    a_rv = '0;
    a_sr = '1;
    repeat (2) step();
    rst_n = 1'b1;
    mreset();
    chk_en = 1'b1;
    #1;
    chk("reset rsp_valid", 176'(a_sv), 176'(0));
    chk("reset rsp_r", 176'(a_out), 176'(0));
    chk("reset req_ready", 176'(a_rr), 176'(0));
  endtask

  initial begin
    forever begin
      step();
      b_rv = NB'($urandom);
      b_sr = NB'($urandom);
      b_x = 22'($urandom);
      b_y = 22'($urandom);
    end
  end

  initial begin
    int cnt2, cnt0, h, gf;
    tbl[0] = '{11'h278, 11'h280, 11'h288};
    tbl[1] = '{11'h000, 11'h270, 11'h000};
    tbl[2] = '{11'h600, 11'h278, 11'h600};
    tbl[3] = '{11'h278, 11'h278, 11'h282};
    tbl[4] = '{11'h378, 11'h280, 11'h388};
    tbl[5] = '{11'h400, 11'h270, 11'h400};
    tbl[6] = '{11'h000, 11'h400, 11'h600};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      int k;
      k = i % NA;
      step();
      a_rv = NA'(1 << k);
      a_x[k*11 +: 11] = tbl[i].x;
      a_y[k*11 +: 11] = tbl[i].y;
      #1 chk($sformatf("vec%0d grant", i), 176'(a_rr), 176'(1 << k));
      step();
      a_rv = '0;
      #1 chk($sformatf("vec%0d early valid", i), 176'(a_sv[k]), 176'(0));
      step();
      #1 chk($sformatf("vec%0d valid", i), 176'(a_sv[k]), 176'(1));
      chk($sformatf("vec%0d product", i), 176'(a_out[k*11 +: 11]), 176'(tbl[i].r));
      step();
      step();
    end
    do_reset();
    a_rv = '1;
    a_sr = '1;
    for (int c = 0; c < 12; c++) begin
      a_x = 44'({$urandom, $urandom});
      a_y = 44'({$urandom, $urandom});
      #1 chk($sformatf("fair grant c%0d", c), 176'(a_rr), 176'(1 << (c % NA)));
      step();
    end
    do_reset();
    a_rv = '1;
    a_sr = 4'b1011;
    cnt2 = 0;
    cnt0 = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      cnt2 += int'(a_rr[2]);
      cnt0 += int'(a_rr[0]);
      step();
    end
    chk("bp issues to 2", 176'(cnt2), 176'(1));
    chk("bp others cycle", 176'(cnt0 >= 2), 176'(1));
    a_sr = '1;
    h = -1;
    gf = -1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (a_sv[2] && a_sr[2] && h < 0) h = c;
      if (a_rr[2] && gf < 0) gf = c;
      step();
    end
    chk("bp regrant after handshake", 176'(gf > h && h >= 0), 176'(1));
    do_reset();
    a_sr = '0;
    step();
    a_rv = 4'b0001;
    step();
    a_rv = '0;
    step();
    step();
    #1 chk("rst pre valid", 176'(a_sv[0]), 176'(1));
    step();
    a_rv = 4'b1000;
    #1 chk("rst pre grant", 176'(a_rr), 176'(4'b1000));
    step();
    a_rv = '0;
    #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst async valid", 176'({a_sv, b_sv}), 176'(0));
    chk("rst async data", 176'(a_out), 176'(0));
    step();
    rst_n = 1'b1;
    mreset();
    chk_en = 1'b1;
    a_sr = '1;
    repeat (6) step();
    a_rv = '1;
    #1 chk("rst ptr zero", 176'(a_rr), 176'(1));
    for (int c = 0; c < 400; c++) begin
      step();
      a_rv = NA'($urandom);
      a_sr = NA'($urandom);
      a_x = 44'({$urandom, $urandom});
      a_y = 44'({$urandom, $urandom});
    end
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
